// File: rtl/fetch_unit_if.sv
// Fetch unit control/status bundle.
// The core drives the inputs; the fetch unit drives the PC and status.
interface fetch_unit_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             Stall;
  logic             ConditionalJump;
  logic             BranchAbsOrRel;
  logic [1:0]       BranchConditions;
  logic [7:0]       Target;
  logic             ZeroFlag;
  logic             NegFlag;
  logic             Ack;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic             BranchTaken;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    output Start, StartAddr, Stall,
    output ConditionalJump, BranchAbsOrRel,
    output BranchConditions, Target,
    output ZeroFlag, NegFlag, Ack,
    input  ProgCtr, Running, Done,
    input  BranchTaken, InstrCount
  );

  modport slave (
    input  Start, StartAddr, Stall,
    input  ConditionalJump, BranchAbsOrRel,
    input  BranchConditions, Target,
    input  ZeroFlag, NegFlag, Ack,
    output ProgCtr, Running, Done,
    output BranchTaken, InstrCount
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter sequencer: IDLE/RUN/HALT with branches,
// stall, halt acknowledge and a saturating retired count.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic         Clk,
  input  logic         ResetN,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bt_q, bt_d;

  logic             cond;
  logic             taken;
  logic [PC_W-1:0]  tgt_abs;
  logic [PC_W-1:0]  tgt_rel;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    cond = 1'b0;
    unique case (bus.BranchConditions)
      2'b00: cond = 1'b1;
      2'b01: cond = bus.ZeroFlag;
      2'b10: cond = ~bus.ZeroFlag;
      2'b11: cond = bus.NegFlag;
    endcase
  end

  assign taken   = bus.ConditionalJump & cond;
  assign tgt_abs = {{(PC_W-8){1'b0}}, bus.Target};
  assign tgt_rel = pc_q
                 + {{(PC_W-8){bus.Target[7]}},
                    bus.Target};

  // Counter sticks at all-ones instead of wrapping
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}})
                 ? cnt_q
                 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    bt_d    = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (bus.Start) begin
          pc_d    = bus.StartAddr;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.Stall) begin
          bt_d = bt_q;
        end else begin
          cnt_d = cnt_inc;
          bt_d  = taken;
          if (bus.Ack) begin
            state_d = HALT;
          end else if (taken) begin
            pc_d = bus.BranchAbsOrRel
                 ? tgt_rel
                 : tgt_abs;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      bt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      bt_q    <= bt_d;
    end
  end

  assign bus.ProgCtr     = pc_q;
  assign bus.InstrCount  = cnt_q;
  assign bus.BranchTaken = bt_q;
  assign bus.Running     = (state_q == RUN);
  assign bus.Done        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

  logic Clk;
  logic ResetN;
  int   n_tests;
  int   n_fail;
  int   exp_cnt;

  fetch_unit_if #(.PC_W(10), .CNT_W(16)) bus ();

  fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic br(
    input logic       cj,
    input logic       rel,
    input logic [1:0] c,
    input logic [7:0] t
  );
    bus.ConditionalJump  = cj;
    bus.BranchAbsOrRel   = rel;
    bus.BranchConditions = c;
    bus.Target           = t;
  endtask

  task automatic run_tick();
    tick();
    exp_cnt++;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    ResetN  = 1'b0;
    bus.Start     = 1'b0;
    bus.StartAddr = '0;
    bus.Stall     = 1'b0;
    bus.ZeroFlag  = 1'b0;
    bus.NegFlag   = 1'b0;
    bus.Ack       = 1'b0;
    br(1'b0, 1'b0, 2'b00, 8'h00);

    #3;
    chk("rst_pc",   32'(bus.ProgCtr), 32'h0);
    chk("rst_cnt",  32'(bus.InstrCount), 32'h0);
    chk("rst_run",  32'(bus.Running), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    chk("rst_bt",   32'(bus.BranchTaken), 32'h0);

    @(negedge Clk);
    ResetN        = 1'b1;
    bus.Start     = 1'b1;
    bus.StartAddr = 10'h010;
    tick();
    bus.Start = 1'b0;
    chk("start_pc",  32'(bus.ProgCtr), 32'h010);
    chk("start_run", 32'(bus.Running), 32'h1);
    chk("start_cnt", 32'(bus.InstrCount), 32'h0);

    run_tick();
    chk("seq_pc1", 32'(bus.ProgCtr), 32'h011);
    run_tick();
    chk("seq_pc2", 32'(bus.ProgCtr), 32'h012);
    run_tick();
    chk("seq_pc3", 32'(bus.ProgCtr), 32'h013);
    chk("seq_cnt", 32'(bus.InstrCount), 32'd3);

    br(1'b1, 1'b0, 2'b00, 8'h20);
    run_tick();
    chk("abs20_pc", 32'(bus.ProgCtr), 32'h020);
    chk("abs20_bt", 32'(bus.BranchTaken), 32'h1);

    bus.ZeroFlag = 1'b1;
    br(1'b1, 1'b1, 2'b01, 8'hFC);
    run_tick();
    chk("relz_pc", 32'(bus.ProgCtr), 32'h01C);
    chk("relz_bt", 32'(bus.BranchTaken), 32'h1);

    br(1'b1, 1'b0, 2'b00, 8'h20);
    run_tick();
    bus.ZeroFlag = 1'b0;
    br(1'b1, 1'b1, 2'b01, 8'hFC);
    run_tick();
    chk("relnz_pc", 32'(bus.ProgCtr), 32'h021);
    chk("relnz_bt", 32'(bus.BranchTaken), 32'h0);

    br(1'b1, 1'b1, 2'b10, 8'h05);
    run_tick();
    chk("nz_pc", 32'(bus.ProgCtr), 32'h026);

    bus.NegFlag = 1'b1;
    br(1'b1, 1'b0, 2'b11, 8'h02);
    run_tick();
    chk("neg_pc", 32'(bus.ProgCtr), 32'h002);

    bus.NegFlag = 1'b0;
    run_tick();
    chk("nneg_pc", 32'(bus.ProgCtr), 32'h003);

    br(1'b0, 1'b0, 2'b00, 8'h55);
    run_tick();
    chk("nocj_pc", 32'(bus.ProgCtr), 32'h004);
    chk("nocj_bt", 32'(bus.BranchTaken), 32'h0);

    br(1'b1, 1'b0, 2'b00, 8'h80);
    run_tick();
    chk("abs80_pc", 32'(bus.ProgCtr), 32'h080);
    chk("mid_cnt",  32'(bus.InstrCount), 32'(exp_cnt));

    bus.Ack = 1'b1;
    run_tick();
    bus.Ack = 1'b0;
    chk("ack_pc",   32'(bus.ProgCtr), 32'h080);
    chk("ack_done", 32'(bus.Done), 32'h1);
    chk("ack_run",  32'(bus.Running), 32'h0);
    chk("ack_cnt",  32'(bus.InstrCount), 32'(exp_cnt));

    tick();
    tick();
    chk("halt_pc",  32'(bus.ProgCtr), 32'h080);
    chk("halt_cnt", 32'(bus.InstrCount), 32'(exp_cnt));
    chk("halt_bt",  32'(bus.BranchTaken), 32'h0);

    br(1'b0, 1'b0, 2'b00, 8'h00);
    bus.Start     = 1'b1;
    bus.StartAddr = 10'h005;
    tick();
    exp_cnt = 0;
    chk("rst2_pc",  32'(bus.ProgCtr), 32'h005);
    chk("rst2_cnt", 32'(bus.InstrCount), 32'h0);
    chk("rst2_run", 32'(bus.Running), 32'h1);

    bus.StartAddr = 10'h100;
    run_tick();
    bus.Start = 1'b0;
    chk("ign_pc",  32'(bus.ProgCtr), 32'h006);
    chk("ign_cnt", 32'(bus.InstrCount), 32'h1);

    bus.Ack = 1'b1;
    run_tick();
    bus.Ack       = 1'b0;
    bus.Start     = 1'b1;
    bus.StartAddr = 10'h3FF;
    tick();
    bus.Start = 1'b0;
    exp_cnt   = 0;
    chk("top_pc", 32'(bus.ProgCtr), 32'h3FF);
    run_tick();
    chk("wrap_pc", 32'(bus.ProgCtr), 32'h000);

    br(1'b1, 1'b0, 2'b00, 8'h40);
    run_tick();
    br(1'b1, 1'b0, 2'b00, 8'h55);
    bus.Stall = 1'b1;
    tick();
    tick();
    chk("stall_pc",  32'(bus.ProgCtr), 32'h040);
    chk("stall_cnt", 32'(bus.InstrCount), 32'(exp_cnt));
    chk("stall_bt",  32'(bus.BranchTaken), 32'h1);
    bus.Stall = 1'b0;
    run_tick();
    chk("unst_pc",  32'(bus.ProgCtr), 32'h055);
    chk("unst_cnt", 32'(bus.InstrCount), 32'(exp_cnt));

    ResetN = 1'b0;
    #1;
    chk("arst_pc",  32'(bus.ProgCtr), 32'h0);
    chk("arst_cnt", 32'(bus.InstrCount), 32'h0);
    chk("arst_bt",  32'(bus.BranchTaken), 32'h0);
    chk("arst_run", 32'(bus.Running), 32'h0);
    chk("arst_dn",  32'(bus.Done), 32'h0);

    @(negedge Clk);
    ResetN        = 1'b1;
    bus.Start     = 1'b1;
    bus.StartAddr = 10'h123;
    tick();
    bus.Start = 1'b0;
    chk("first_pc",  32'(bus.ProgCtr), 32'h123);
    chk("first_run", 32'(bus.Running), 32'h1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
